rvfi_check_sequencer: RTL and testbench
=======================================

# rvfi_check_sequencer

Generates the `reset`, `trig` and `check` control strobes that drive an RVFI formal check (such as the instruction-uniqueness check) from a bounded cycle schedule. It sits directly upstream of the check module in each check wrapper. It owns the post-reset settling window, the window in which the check may trigger, and the single cycle at which the check's assertion fires. It qualifies a free trigger request (solver- or bench-driven) with a retirement on the selected RVFI channel, so `trig` always coincides with a valid retirement.

## Interface
- `NRET`, 1: number of RVFI retire channels.
- `CHANNEL_IDX`, 0: channel whose retirement qualifies `trig`; must be < `NRET`.
- `RESET_CYCLES`, 1: cycles `check_reset` stays high after `reset` falls; range 0..255.
- `TRIG_MIN`, 0: first schedule cycle in which `trig` may fire.
- `TRIG_MAX`, 15: last schedule cycle in which `trig` may fire; must be ≥ `TRIG_MIN`.
- `CHECK_CYCLE`, 20: schedule cycle at which `check` fires; must be > `TRIG_MAX`.
- Illegal parameter combinations are an elaboration-time error.

- `clock` input 1: sole clock; all state updates on posedge.
- `reset` input 1: one clock; reset is synchronous and active-high.
- `trig_req` input 1: free trigger request.
- `rvfi_valid` input `NRET`: per-channel retire valid.
- `check_reset` output 1: reset strobe to the downstream check.
- `trig` output 1: trigger strobe; at most one pulse per run.
- `check` output 1: assertion strobe; exactly one pulse per triggered run.
- `done` output 1: run finished; sticky until `reset`.
- `missed` output 1: window closed without a trigger; sticky until `reset`.
- `cycle` output 16: schedule cycle index.

## Operation
- FSM states: `RST`, `SETTLE`, `ARMED`, `TRIGGERED`, `FINISHED`.
  - `RST`: entered whenever `reset` is sampled high, from any state.
  - `RST` → `SETTLE` when `reset` is low and `RESET_CYCLES` > 0.
  - `RST` → `ARMED` when `reset` is low and `RESET_CYCLES` = 0.
  - `SETTLE` → `ARMED` after `RESET_CYCLES` cycles in `SETTLE`.
  - `ARMED` → `TRIGGERED` on a cycle with `trig`=1.
  - `ARMED` → `FINISHED` with `missed` set when `cycle` = `TRIG_MAX` and `trig`=0.
  - `TRIGGERED` → `FINISHED` on the cycle where `check`=1.
  - `FINISHED` is terminal until `reset`.
- `check_reset` = 1 in `RST` and `SETTLE`, else 0.
- `cycle` is 0 in the first cycle of `ARMED`, +1 per cycle after that, saturating at 0xFFFF. It holds 0 in `RST` and `SETTLE`.
- `trig` (combinational) = state `ARMED` && `TRIG_MIN` ≤ `cycle` ≤ `TRIG_MAX` && `trig_req` && `rvfi_valid[CHANNEL_IDX]`.
- `check` (combinational) = state `TRIGGERED` && `cycle` = `CHECK_CYCLE`.
- `done` = state `FINISHED` (registered).
- `missed` is a register: set on the `ARMED` → `FINISHED` timeout transition, cleared only by `reset`.
- Validity on channels other than `CHANNEL_IDX` never affects `trig`.

## Timing
- Reset values: state `RST`, settle counter 0, `cycle` 0, `check_reset` 1, `trig` 0, `check` 0, `done` 0, `missed` 0.
- `trig` and `check` have zero latency: they are valid in the same cycle as their qualifying inputs, because the downstream check samples `trig` alongside the RVFI signals of that cycle.
- `done` rises one cycle after `check`, or one cycle after the `TRIG_MAX` timeout.
- `trig_req` at `cycle` = `TRIG_MIN` − 1 or `TRIG_MAX` + 1: ignored.
- `trig_req` at exactly `cycle` = `TRIG_MIN` or `TRIG_MAX`: accepted.
- A trigger at `cycle` = `TRIG_MAX` has priority over the timeout: `trig`=1, `missed` stays 0.
- A second `trig_req` after triggering is ignored.
- `reset` mid-run (any state): on the next cycle state is `RST`, all outputs are at reset values, and any pending `check` is abandoned.
- `reset` together with a qualifying `trig_req` in the same cycle: reset wins and `trig`=0.

## Structure
- Package `rvfi_seq_pkg` holds:
  - the state enum typedef `rvfi_seq_state_t`;
  - `RVFI_SEQ_CYCLE_W` = 16;
  - `RVFI_SEQ_SETTLE_W` = 8.
- One sub-module, `rvfi_seq_sat_counter`: a parameterised-width saturating counter with sync clear and enable, instantiated twice (settle counter and `cycle` counter).
- The FSM and strobe logic live in the top module.

## Test plan
Parameters for all scenarios: `NRET`=2, `CHANNEL_IDX`=1, `RESET_CYCLES`=2, `TRIG_MIN`=3, `TRIG_MAX`=6, `CHECK_CYCLE`=10.
- **Nominal run:** release `reset`; drive `trig_req`=1 and `rvfi_valid`=2'b10 at `cycle` 4 → `check_reset` high for 2 cycles after release; `trig`=1 only at `cycle` 4; `check`=1 only at `cycle` 10; `done`=1 from `cycle` 11; `missed`=0.
- **Window edges and channel qualification:**
  - `trig_req` with `rvfi_valid`=2'b10 at `cycle` 2 → `trig`=0.
  - `trig_req` with `rvfi_valid`=2'b01 at `cycle` 5 → `trig`=0.
  - `trig_req` with `rvfi_valid`=2'b10 at `cycle` 6 → `trig`=1, `missed`=0.
- **Timeout:** no qualifying request in cycles 3..6 → `done`=1 and `missed`=1 from `cycle` 7; `check` never pulses.
- **Repeat requests:** `trig_req`=1 and `rvfi_valid`=2'b11 held in every cycle → exactly one `trig` pulse (`cycle` 3) and exactly one `check` pulse (`cycle` 10).
- **Mid-run reset:** `reset` pulsed at `cycle` 8 after a trigger at `cycle` 3 → `check_reset`=1, `cycle`=0, `done`=0 the next cycle; no `check` at the old `cycle` 10; a fresh schedule follows.
- **Zero settle:** re-elaborate with `RESET_CYCLES`=0 → `check_reset` falls in the first cycle after `reset` is released, with `cycle`=0 in that cycle.

Source files
------------

// File: rtl/rvfi_seq_pkg.sv
// Shared types and widths for the RVFI check sequencer.
//   rvfi_seq_state_t  : sequencer FSM state encoding
//   RVFI_SEQ_CYCLE_W  : width of the schedule cycle counter
//   RVFI_SEQ_SETTLE_W : width of the post-reset settle counter
package rvfi_seq_pkg;

    localparam int RVFI_SEQ_CYCLE_W  = 16;
    localparam int RVFI_SEQ_SETTLE_W = 8;

    typedef enum logic [2:0] {
        RST       = 3'd0,
        SETTLE    = 3'd1,
        ARMED     = 3'd2,
        TRIGGERED = 3'd3,
        FINISHED  = 3'd4
    } rvfi_seq_state_t;

endpackage

// File: rtl/rvfi_seq_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
//   clock : clock, all updates on posedge
//   reset : synchronous active-high reset, count returns to 0
//   clear : synchronous clear to 0 (wins over en)
//   en    : count enable; the count sticks at all-ones
//   count : current count value
module rvfi_seq_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rvfi_check_sequencer.sv
// Control-strobe sequencer for an RVFI formal check. After reset it holds
// the check in reset for RESET_CYCLES, then runs a cycle schedule in which
// a trigger request qualified by a retirement on channel CHANNEL_IDX may
// fire trig inside [TRIG_MIN, TRIG_MAX]; check fires at CHECK_CYCLE.
//   clock       : clock, all updates on posedge
//   reset       : synchronous active-high reset
//   trig_req    : free trigger request
//   rvfi_valid  : per-channel retire valid
//   check_reset : reset strobe to the downstream check
//   trig        : trigger strobe (combinational, at most once per run)
//   check       : assertion strobe (combinational, once per triggered run)
//   done        : run finished, sticky until reset
//   missed      : window closed without a trigger, sticky until reset
//   cycle       : schedule cycle index
module rvfi_check_sequencer
    import rvfi_seq_pkg::*;
#(
    parameter int NRET         = 1,
    parameter int CHANNEL_IDX  = 0,
    parameter int RESET_CYCLES = 1,
    parameter int TRIG_MIN     = 0,
    parameter int TRIG_MAX     = 15,
    parameter int CHECK_CYCLE  = 20
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        trig_req,
    input  logic [NRET-1:0]             rvfi_valid,
    output logic                        check_reset,
    output logic                        trig,
    output logic                        check,
    output logic                        done,
    output logic                        missed,
    output logic [RVFI_SEQ_CYCLE_W-1:0] cycle
);

    generate
        if (NRET < 1 || CHANNEL_IDX < 0 || CHANNEL_IDX >= NRET ||
            RESET_CYCLES < 0 || RESET_CYCLES > 255 || TRIG_MIN < 0 ||
            TRIG_MAX < TRIG_MIN || CHECK_CYCLE <= TRIG_MAX ||
            CHECK_CYCLE > 65535) begin : g_bad_params
            $error("rvfi_check_sequencer: illegal parameter combination");
        end
    endgenerate

    rvfi_seq_state_t state_q;
    rvfi_seq_state_t state_d;
    logic            missed_q;
    logic            missed_d;

    logic [RVFI_SEQ_SETTLE_W-1:0] settle_cnt;
    logic [RVFI_SEQ_CYCLE_W-1:0]  cycle_cnt;
    logic                         settle_clear;
    logic                         cycle_clear;
    logic                         settle_done;
    logic                         in_window;
    logic                         timeout;

    // Only the selected channel qualifies trig; the rest are intentionally ignored.
    logic unused_valid;
    assign unused_valid = ^rvfi_valid;

    // The settle counter only runs while in SETTLE; the schedule counter is
    // pinned to 0 through RST/SETTLE so the first ARMED cycle reads 0.
    assign settle_clear = (state_q != SETTLE);
    assign cycle_clear  = (state_q == RST) || (state_q == SETTLE);

    rvfi_seq_sat_counter #(
        .WIDTH (RVFI_SEQ_SETTLE_W)
    ) u_settle_cnt (
        .clock (clock),
        .reset (reset),
        .clear (settle_clear),
        .en    (1'b1),
        .count (settle_cnt)
    );

    rvfi_seq_sat_counter #(
        .WIDTH (RVFI_SEQ_CYCLE_W)
    ) u_cycle_cnt (
        .clock (clock),
        .reset (reset),
        .clear (cycle_clear),
        .en    (1'b1),
        .count (cycle_cnt)
    );

    // Compare in signed int so a zero bound does not become a constant compare.
    assign settle_done = (int'(settle_cnt) == RESET_CYCLES - 1);
    assign in_window   = (int'(cycle_cnt) >= TRIG_MIN) && (int'(cycle_cnt) <= TRIG_MAX);
    // A trigger on the last window cycle takes priority over the timeout.
    assign timeout     = (state_q == ARMED) && (int'(cycle_cnt) == TRIG_MAX) && !trig;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= RST;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            missed_q <= missed_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        missed_d = missed_q;
        if (reset) begin
            state_d  = RST;
            missed_d = 1'b0;
        end else begin
            case (state_q)
                RST:       state_d = (RESET_CYCLES > 0) ? SETTLE : ARMED;
                SETTLE:    if (settle_done) state_d = ARMED;
                ARMED: begin
                    if (trig) begin
                        state_d = TRIGGERED;
                    end else if (timeout) begin
                        state_d  = FINISHED;
                        missed_d = 1'b1;
                    end
                end
                TRIGGERED: if (check) state_d = FINISHED;
                FINISHED:  state_d = FINISHED;
                default:   state_d = RST;
            endcase
        end
    end

    // Outputs. trig/check are gated by reset so a reset cycle never strobes.
    always_comb begin
        check_reset = (state_q == RST) || (state_q == SETTLE);
        trig        = (state_q == ARMED) && in_window && trig_req &&
                      rvfi_valid[CHANNEL_IDX] && !reset;
        check       = (state_q == TRIGGERED) && (int'(cycle_cnt) == CHECK_CYCLE) &&
                      !reset;
        done        = (state_q == FINISHED);
        missed      = missed_q;
        cycle       = cycle_cnt;
    end

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
module tb_rvfi_check_sequencer;

    localparam int NRET = 2;
    localparam int CH   = 1;
    localparam int TMIN = 3;
    localparam int TMAX = 6;
    localparam int CHK  = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       trig_req;
    logic [1:0] rvfi_valid;

    logic        cr_a, trig_a, check_a, done_a, missed_a;
    logic [15:0] cyc_a;
    logic        cr_b, trig_b, check_b, done_b, missed_b;
    logic [15:0] cyc_b;

    rvfi_check_sequencer #(
        .NRET(NRET), .CHANNEL_IDX(CH), .RESET_CYCLES(2),
        .TRIG_MIN(TMIN), .TRIG_MAX(TMAX), .CHECK_CYCLE(CHK)
    ) dut (
        .clock(clk), .reset(reset), .trig_req(trig_req), .rvfi_valid(rvfi_valid),
        .check_reset(cr_a), .trig(trig_a), .check(check_a),
        .done(done_a), .missed(missed_a), .cycle(cyc_a)
    );

    rvfi_check_sequencer #(
        .NRET(NRET), .CHANNEL_IDX(CH), .RESET_CYCLES(0),
        .TRIG_MIN(TMIN), .TRIG_MAX(TMAX), .CHECK_CYCLE(CHK)
    ) dut_zero (
        .clock(clk), .reset(reset), .trig_req(trig_req), .rvfi_valid(rvfi_valid),
        .check_reset(cr_b), .trig(trig_b), .check(check_b),
        .done(done_b), .missed(missed_b), .cycle(cyc_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Index 0: RESET_CYCLES=2 instance, index 1: RESET_CYCLES=0 instance.
    // age = cycles since reset was released; schedule = age - settle length.
    bit model_valid = 1'b0;
    int m_rc[2]       = '{2, 0};
    bit m_rst[2]      = '{1'b1, 1'b1};
    int m_age[2]      = '{0, 0};
    int m_trig_cyc[2] = '{-1, -1};

    function automatic bit m_armed(input int d);
        return !m_rst[d] && (m_age[d] >= m_rc[d]);
    endfunction

    function automatic int m_sched(input int d);
        int s;
        if (!m_armed(d)) return 0;
        s = m_age[d] - m_rc[d];
        return (s > 65535) ? 65535 : s;
    endfunction

    function automatic bit exp_trig(input int d);
        int s = m_sched(d);
        return m_armed(d) && (m_trig_cyc[d] < 0) && (s >= TMIN) && (s <= TMAX) &&
               trig_req && rvfi_valid[CH] && !reset;
    endfunction

    function automatic bit exp_check(input int d);
        return m_armed(d) && (m_trig_cyc[d] >= 0) && (m_sched(d) == CHK) && !reset;
    endfunction

    function automatic bit exp_missed(input int d);
        return m_armed(d) && (m_trig_cyc[d] < 0) && (m_sched(d) > TMAX);
    endfunction

    function automatic bit exp_done(input int d);
        return m_armed(d) && (((m_trig_cyc[d] < 0) && (m_sched(d) > TMAX)) ||
                              ((m_trig_cyc[d] >= 0) && (m_sched(d) > CHK)));
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit t;
            int s;
            t = exp_trig(d);
            s = m_sched(d);
            if (reset) begin
                m_rst[d]      = 1'b1;
                m_age[d]      = 0;
                m_trig_cyc[d] = -1;
            end else if (m_rst[d]) begin
                m_rst[d] = 1'b0;
                m_age[d] = 0;
            end else begin
                if (t) m_trig_cyc[d] = s;
                m_age[d] = m_age[d] + 1;
            end
        end
        if (reset) model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            for (int d = 0; d < 2; d++) begin
                logic        cr, tg, ck, dn, ms;
                logic [15:0] cy;
                if (d == 0) {cr, tg, ck, dn, ms, cy} = {cr_a, trig_a, check_a, done_a, missed_a, cyc_a};
                else        {cr, tg, ck, dn, ms, cy} = {cr_b, trig_b, check_b, done_b, missed_b, cyc_b};
                chk($sformatf("m%0d_check_reset", d), cr, !m_armed(d));
                chk($sformatf("m%0d_trig", d),        tg, exp_trig(d));
                chk($sformatf("m%0d_check", d),       ck, exp_check(d));
                chk($sformatf("m%0d_done", d),        dn, exp_done(d));
                chk($sformatf("m%0d_missed", d),      ms, exp_missed(d));
                chk($sformatf("m%0d_cycle", d),       cy, m_sched(d));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input logic r, input logic [1:0] v);
        trig_req   = r;
        rvfi_valid = v;
        #1;
    endtask

    // Reset, release, and walk to schedule cycle 0 of the main instance.
    task automatic arm(input string name);
        $display("txn %s", name);
        reset = 1'b1;
        drv(1'b0, 2'b00);
        nxt();
        reset = 1'b0;
        nxt();
        chk("settle1_check_reset", cr_a, 1);
        chk("zero_check_reset", cr_b, 0);
        chk("zero_cycle", cyc_b, 0);
        nxt();
        chk("settle2_check_reset", cr_a, 1);
        nxt();
        chk("armed_check_reset", cr_a, 0);
        chk("armed_cycle", cyc_a, 0);
    endtask

    int n_trig, n_check;

    initial begin
        reset      = 1'b1;
        trig_req   = 1'b0;
        rvfi_valid = 2'b00;
        nxt();
        nxt();
        $display("txn reset_state");
        drv(1'b1, 2'b10);
        chk("rst_check_reset", cr_a, 1);
        chk("rst_cycle", cyc_a, 0);
        chk("rst_trig", trig_a, 0);
        chk("rst_check", check_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_missed", missed_a, 0);

        // Nominal run
        arm("nominal");
        n_trig = 0; n_check = 0;
        for (int c = 0; c <= 12; c++) begin
            drv(c == 4, (c == 4) ? 2'b10 : 2'b00);
            n_trig  += int'(trig_a);
            n_check += int'(check_a);
            if (c == 4)  chk("nom_trig_c4", trig_a, 1);
            if (c == 10) chk("nom_check_c10", check_a, 1);
            if (c == 11) begin
                chk("nom_done_c11", done_a, 1);
                chk("nom_missed_c11", missed_a, 0);
            end
            nxt();
        end
        chk("nom_trig_count", n_trig, 1);
        chk("nom_check_count", n_check, 1);

        // Window edges and channel qualification
        arm("window_edges");
        for (int c = 0; c <= 11; c++) begin
            case (c)
                2: begin drv(1'b1, 2'b10); chk("win_early_c2", trig_a, 0); end
                5: begin drv(1'b1, 2'b01); chk("win_wrong_chan_c5", trig_a, 0); end
                6: begin drv(1'b1, 2'b10); chk("win_last_c6", trig_a, 1); end
                default: drv(1'b0, 2'b00);
            endcase
            if (c == 7)  chk("win_missed_c7", missed_a, 0);
            if (c == 10) chk("win_check_c10", check_a, 1);
            nxt();
        end

        // Timeout
        arm("timeout");
        n_check = 0;
        for (int c = 0; c <= 12; c++) begin
            if (c == 8) begin
                drv(1'b1, 2'b10);
                chk("to_late_c8", trig_a, 0);
            end else begin
                drv(1'b0, 2'b00);
            end
            n_check += int'(check_a);
            if (c == 6) chk("to_done_c6", done_a, 0);
            if (c == 7) begin
                chk("to_done_c7", done_a, 1);
                chk("to_missed_c7", missed_a, 1);
            end
            nxt();
        end
        chk("to_check_count", n_check, 0);

        // Repeat requests
        arm("repeat_requests");
        n_trig = 0; n_check = 0;
        for (int c = 0; c <= 14; c++) begin
            drv(1'b1, 2'b11);
            n_trig  += int'(trig_a);
            n_check += int'(check_a);
            if (c == 3)  chk("rep_trig_c3", trig_a, 1);
            if (c == 10) chk("rep_check_c10", check_a, 1);
            nxt();
        end
        chk("rep_trig_count", n_trig, 1);
        chk("rep_check_count", n_check, 1);

        // Mid-run reset
        arm("midrun_reset");
        for (int c = 0; c <= 7; c++) begin
            drv(c == 3, (c == 3) ? 2'b10 : 2'b00);
            if (c == 3) chk("mid_trig_c3", trig_a, 1);
            nxt();
        end
        reset = 1'b1;
        drv(1'b0, 2'b00);
        nxt();
        chk("mid_after_check_reset", cr_a, 1);
        chk("mid_after_cycle", cyc_a, 0);
        chk("mid_after_done", done_a, 0);
        reset = 1'b0;
        n_check = 0;
        for (int k = 0; k <= 17; k++) begin
            drv(k == 7, (k == 7) ? 2'b10 : 2'b00);
            if (k <= 2) n_check += int'(check_a);
            if (k == 3) chk("mid_fresh_cycle0", cyc_a, 0);
            if (k == 7) chk("mid_fresh_trig_c4", trig_a, 1);
            if (k == 13) chk("mid_fresh_check_c10", check_a, 1);
            nxt();
        end
        chk("mid_abandoned_check", n_check, 0);

        // Reset together with a qualifying request
        arm("reset_vs_trig");
        for (int c = 0; c <= 3; c++) begin
            drv(1'b0, 2'b00);
            nxt();
        end
        reset = 1'b1;
        drv(1'b1, 2'b10);
        chk("rvt_trig_c4", trig_a, 0);
        nxt();
        chk("rvt_check_reset", cr_a, 1);
        reset = 1'b0;
        drv(1'b0, 2'b00);
        nxt();
        nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
